// File: rtl/sync_filt_nd.sv
// sync_filt_nd
//   Brings WIDTH independent asynchronous level signals into the clk domain.
//   Each channel passes through a STAGES-deep flop chain and then a
//   stability filter. The filter only lets q follow the synchronized value
//   after that value has been held for FILT_CNT consecutive cycles.
//   Registered one-cycle rise/fall pulses mark every change of q.
//
// Parameters
//   WIDTH    : number of independent channels
//   STAGES   : synchronizer depth per channel (legal range 2..4)
//   RST_VAL  : reset value of the sync stages and of q, one bit per channel
//   FILT_CNT : cycles a new value must persist before q follows (1..255,
//              1 = no filtering)
//
// Ports
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous level inputs (false path into the first stage)
//   q     : synchronized, filtered level
//   rise  : one-cycle pulse when q[i] goes 0->1
//   fall  : one-cycle pulse when q[i] goes 1->0
//
// Latency: a d change made before edge 1 reaches the last sync stage at edge
// STAGES. q, rise and fall update at edge STAGES+FILT_CNT.
module sync_filt_nd #(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
  parameter int               FILT_CNT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int            CW  = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] THR = CW'(FILT_CNT - 1);

  // Illegal configurations must stop elaboration.
  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_filt_nd: STAGES must be in 2..4");
    end
    if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_filt
      $error("sync_filt_nd: FILT_CNT must be in 1..255");
    end
  endgenerate

  // Synchronizer chain. These flops are kept as a plain register chain with
  // nothing between them, so the tools must not merge or retime them.
  (* dont_touch = "true", preserve *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  logic [WIDTH-1:0] s;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_comb begin
    sync_d[0] = d;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[STAGES-1];

  // Stability filter. The counter runs only while s disagrees with q.
  // Any cycle where s agrees with q clears it, so a glitch shorter than
  // FILT_CNT cycles never moves q. The counter stops at THR and never wraps,
  // because reaching THR with s still different updates q and clears it.
  always_comb begin
    q_d    = q_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != q_q[i]) begin
        if (cnt_q[i] == THR) begin
          q_d[i]    = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      q_q    <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule
